imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Upstream boot stage for the 5-stage pipeline. Receives a program as a byte stream
//  with a valid/ready handshake, assembles 32-bit big-endian instruction words and
//  writes them into the I_FETCH instruction memory. Holds the pipeline in reset
//  (pipe_hold) until the whole image is written, then releases it.
//  Stream format: 16-bit word count N (MSB byte first), followed by N words of 4 bytes each.
// PARAMETERS
//  ADDR_W  7    word-address width of the instruction memory
//  DEPTH   128  words of instruction memory; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       single clock; all state updates on the rising edge
//  rst         in   1       asynchronous, active-high reset
//  in_valid    in   1       a byte is present on in_data
//  in_data     in   8       stream byte
//  in_ready    out  1       loader accepts the byte; a transfer occurs when in_valid & in_ready
//  restart     in   1       one-cycle pulse; re-arms the loader from DONE or ERROR
//  imem_we     out  1       one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_W  word address of the write
//  imem_wdata  out  32      instruction word to write
//  pipe_hold   out  1       held high while loading; drives the pipeline reset
//  done        out  1       image fully written
//  error       out  1       header rejected
// BEHAVIOUR
//  - Reset (async): state=HDR_HI. in_ready=0 during reset, then 1 in HDR_HI.
//    imem_we=0, imem_addr=0, imem_wdata=0, pipe_hold=1, done=0, error=0. Counters are cleared.
//  - States: HDR_HI -> HDR_LO -> DATA -> DONE; HDR_LO -> ERROR.
//    HDR_HI: on a transfer, latch count[15:8], then go to HDR_LO.
//    HDR_LO: on a transfer, form N. If N==0 or N>DEPTH, go to ERROR; otherwise go to DATA.
//    DATA: shift bytes MSB-first; a 2-bit byte counter tracks position.
//    DONE/ERROR: in_ready=0. restart moves to HDR_HI, clears counters, and sets pipe_hold=1 on the next edge.
//  - in_ready = 1 in HDR_HI, HDR_LO and DATA; 0 otherwise. in_ready is not gated by in_valid.
//  - Word write: the edge that accepts the 4th byte of word k registers
//    imem_we=1, imem_addr=k, imem_wdata={b0,b1,b2,b3}. These are visible the following cycle.
//    imem_we lasts exactly 1 cycle. imem_addr/imem_wdata hold their value until the next write.
//  - Consecutive words can be written as often as every 4 cycles. There are no bubbles between words.
//  - Completion: when the last byte of word N-1 is accepted, the state goes to DONE on that edge.
//    done=1 and pipe_hold=0 are registered to assert one cycle later, i.e. in the same cycle
//    as the final imem_we. The pipeline therefore leaves reset no earlier than the final write commit.
//  - Word counter is ADDR_W+1 bits and compares against N. It never wraps, because N<=DEPTH is checked.
//  - in_valid low mid-word: the partial word and counters are held indefinitely. There is no timeout.
//  - restart outside DONE/ERROR is ignored.
//  - restart together with in_valid in DONE: the byte is not accepted (in_ready=0 that cycle).
//  - error=1 and pipe_hold=1 remain set in ERROR until restart or rst.
//  - rst mid-load: everything is aborted immediately. Partially written memory is not cleared.
//    The next load overwrites it.
//  - Writes beyond N never occur. Trailing stream bytes after DONE stay un-accepted.
// STRUCTURE
//  - Shared include loader_defs.vh: state encodings (HDR_HI, HDR_LO, DATA, DONE, ERROR),
//    HDR_BYTES=2, WORD_BYTES=4.
//  - One sub-module, word_assembler: an 8->32 shift register with a byte counter and a
//    word_valid pulse. The FSM, header logic and counters stay in imem_loader.
//  - All outputs are registered. in_ready is decoded from the state register.
// TESTING
//  1. Reset: assert rst mid-cycle -> outputs immediately take their reset values,
//     pipe_hold=1 and in_ready=0; after release in_ready=1.
//  2. N=2 with bytes 00 02 | 20 08 00 05 | AC 09 00 04 sent back-to-back ->
//     imem_we at addr 0 with 0x20080005, then addr 1 with 0xAC090004, 4 cycles apart.
//     done=1 and pipe_hold=0 in the cycle of the 2nd write.
//  3. Header 00 00, and separately header 00 81 (129 > DEPTH) -> ERROR: error=1, in_ready=0,
//     no imem_we. restart then returns the loader to HDR_HI.
//  4. Random in_valid gaps (50% duty) with N=3 -> same writes and data as with no gaps.
//     The word count is exact and there is no extra imem_we.
//  5. After DONE, drive in_valid=1 plus a restart pulse -> byte not accepted that cycle.
//     Next cycle pipe_hold=1, done=0, in_ready=1; a full reload of N=1 succeeds.
//  6. rst asserted after 5 bytes of an N=2 load -> abort. A subsequent N=1 load writes
//     addr 0 only, and done asserts.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader: FSM state
//   encodings, stream framing constants and a state decode helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 2;                    // 16-bit word count, MSB first
  localparam int WORD_BYTES = 4;                    // big-endian 32-bit instruction
  localparam int BCNT_W     = $clog2(WORD_BYTES);   // byte-in-word counter width

  // States in which the loader takes stream bytes.
  function automatic logic accepting(state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream input, restart pulse, instruction-memory write port and
//   pipeline status of the boot loader.
//   slave  : loader side (takes stream, drives memory write and status)
//   master : boot source / testbench side
interface imem_loader_if #(parameter int ADDR_W = 7);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              pipe_hold;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, imem_we, imem_addr, imem_wdata, pipe_hold, done, error
  );

  modport master (
    output in_valid, in_data, restart,
    input  in_ready, imem_we, imem_addr, imem_wdata, pipe_hold, done, error
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler
//   8->32 shift register. Bytes arrive MSB first; the byte that completes a
//   word registers the full word and a one-cycle word_valid pulse.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear of partial word and byte counter
//   byte_en    : accept byte_in this cycle
//   byte_in    : stream byte
//   last_byte  : next accepted byte completes the word (decoded from counter)
//   word_valid : registered pulse, one cycle, when word updates
//   word       : last completed word; holds until the next completion
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int                SH_W = 8 * (WORD_BYTES - 1);
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(WORD_BYTES - 1);

  logic [BCNT_W-1:0] cnt_q,  cnt_d;
  logic [SH_W-1:0]   sh_q,   sh_d;
  logic [31:0]       word_q, word_d;
  logic              wv_q,   wv_d;

  assign last_byte = (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clr) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_en) begin
      if (last_byte) begin
        // Only the leading bytes are buffered; the final byte goes straight
        // into the output word.
        word_d = {sh_q, byte_in};
        wv_d   = 1'b1;
        cnt_d  = '0;
      end else begin
        sh_d  = {sh_q[SH_W-9:0], byte_in};
        cnt_d = cnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

  assign word_valid = wv_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot stage: takes a byte stream (16-bit word count N, MSB first, then N
//   big-endian 32-bit words), writes the words into instruction memory at
//   addresses 0..N-1 and holds the pipeline in reset until the image is in.
//   clk, rst : clock, async active-high reset
//   bus      : imem_loader_if slave (stream in, restart, imem write, status)
//   Status: pipe_hold high until DONE; error high on a header of 0 or >DEPTH.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam logic [15:0]     DEPTH16 = 16'(DEPTH);
  localparam logic [ADDR_W:0] WONE    = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              pipe_hold_q, pipe_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              asm_clr, asm_en, asm_last, asm_we;
  logic [31:0]       asm_word;
  logic [15:0]       n_hdr;

  assign xfer   = bus.in_valid & in_ready_q;
  assign n_hdr  = {hi_q, bus.in_data};
  assign asm_en = xfer && (state_q == ST_DATA);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    asm_clr = 1'b0;
    case (state_q)
      ST_HDR_HI: if (xfer) begin
        hi_d    = bus.in_data;
        state_d = ST_HDR_LO;
      end
      ST_HDR_LO: if (xfer) begin
        // The range check guarantees N fits in the word counter, so the
        // counter never wraps and no write lands beyond DEPTH.
        if (n_hdr == 16'd0 || n_hdr > DEPTH16) begin
          state_d = ST_ERROR;
        end else begin
          n_d     = n_hdr[ADDR_W:0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (xfer && asm_last) begin
        addr_d = wcnt_q[ADDR_W-1:0];
        wcnt_d = wcnt_q + WONE;
        if (wcnt_q + WONE == n_q) state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: if (bus.restart) begin
        state_d = ST_HDR_HI;
        hi_d    = '0;
        n_d     = '0;
        wcnt_d  = '0;
        asm_clr = 1'b1;
      end
      default: state_d = ST_HDR_HI;
    endcase
  end

  // Status flags are registered from the next state so they line up with the
  // write strobe of the final word.
  always_comb begin
    in_ready_d  = accepting(state_d);
    pipe_hold_d = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HDR_HI;
      hi_q        <= '0;
      n_q         <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b0;
      pipe_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      pipe_hold_q <= pipe_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_en    (asm_en),
    .byte_in    (bus.in_data),
    .last_byte  (asm_last),
    .word_valid (asm_we),
    .word       (asm_word)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = asm_we;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = asm_word;
  assign bus.pipe_hold  = pipe_hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Write monitor, sampled 1 time unit after the edge.
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic              wdone[$];
  logic              whold[$];
  int                wcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rst === 1'b0 && bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
      wdone.push_back(bus.done);
      whold.push_back(bus.pipe_hold);
      wcyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    wa.delete(); wd.delete(); wdone.delete(); whold.delete(); wcyc.delete();
  endtask

  // Reference model: the image the stream describes.
  logic [31:0] exp_q[$];
  bit          exp_err;

  function automatic void model(input logic [7:0] s[$]);
    int n;
    exp_q.delete();
    n = int'({s[0], s[1]});
    exp_err = (n == 0) || (n > DEPTH);
    if (!exp_err)
      for (int k = 0; k < n; k++)
        if (5 + 4*k < s.size())
          exp_q.push_back({s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Drive a byte stream; with gaps, in_valid has a 50% duty.
  task automatic send(input logic [7:0] s[$], input bit gaps);
    int i = 0;
    int budget = 0;
    while (i < s.size() && budget < 2000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = s[i];
      if (bus.in_valid && bus.in_ready === 1'b1) i++;
      cycle();
      budget++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (i !== s.size()) begin
      n_fail++;
      $display("FAIL send_timeout: sent %0d bytes, required %0d", i, s.size());
    end
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    cycle();
    bus.restart = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 40 && bus.done !== 1'b1; c++) cycle();
    repeat (2) cycle();
  endtask

  task automatic check_image(input string name);
    n_checks++;
    if (wa.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, wa.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wa.size(); k++) begin
      n_checks++;
      if (wa[k] !== ADDR_W'(k) || wd[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s_write%0d: got addr %0d data %h, required addr %0d data %h",
                 name, k, wa[k], wd[k], k, exp_q[k]);
      end
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.pipe_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_final: got done %b hold %b rdy %b, required 1 0 0",
               name, bus.done, bus.pipe_hold, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    logic [7:0] s[$];
    cycle();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.pipe_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got rdy %b hold %b, required 1 1", bus.in_ready, bus.pipe_hold);
    end
    s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
    send(s, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.pipe_hold !== 1'b1 || bus.imem_we !== 1'b0 ||
        bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got rdy %b hold %b we %b addr %0d data %h done %b err %b, required 0 1 0 0 0 0 0",
               bus.in_ready, bus.pipe_hold, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done, bus.error);
    end
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.pipe_hold !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rearm: got rdy %b hold %b done %b, required 1 1 0",
               bus.in_ready, bus.pipe_hold, bus.done);
    end
    clear_mon();
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
    model(s);
    clear_mon();
    send(s, 1'b0);
    wait_done();
    check_image("b2b");
    n_checks++;
    if (wcyc.size() != 2 || wcyc[1] - wcyc[0] != 4 || wdone[0] !== 1'b0 || wdone[1] !== 1'b1 ||
        whold[0] !== 1'b1 || whold[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d writes gap %0d done %b/%b hold %b/%b, required 2 4 0/1 1/0",
               wcyc.size(), (wcyc.size() == 2) ? wcyc[1] - wcyc[0] : -1,
               (wdone.size() > 0) ? wdone[0] : 1'bx, (wdone.size() > 1) ? wdone[1] : 1'bx,
               (whold.size() > 0) ? whold[0] : 1'bx, (whold.size() > 1) ? whold[1] : 1'bx);
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] s[$];
    logic [15:0] hdrs[2];
    hdrs[0] = 16'h0000;
    hdrs[1] = 16'h0081;
    do_restart();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.pipe_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_done: got rdy %b done %b hold %b, required 1 0 1",
               bus.in_ready, bus.done, bus.pipe_hold);
    end
    for (int h = 0; h < 2; h++) begin
      s = '{hdrs[h][15:8], hdrs[h][7:0]};
      model(s);
      clear_mon();
      send(s, 1'b0);
      repeat (3) cycle();
      n_checks++;
      if (bus.error !== exp_err || bus.in_ready !== 1'b0 || bus.pipe_hold !== 1'b1 ||
          bus.done !== 1'b0 || wa.size() != 0) begin
        n_fail++;
        $display("FAIL bad_hdr_%h: got err %b rdy %b hold %b done %b writes %0d, required %b 0 1 0 0",
                 hdrs[h], bus.error, bus.in_ready, bus.pipe_hold, bus.done, wa.size(), exp_err);
      end
      do_restart();
      n_checks++;
      if (bus.error !== 1'b0 || bus.in_ready !== 1'b1 || bus.pipe_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_hdr_restart_%h: got err %b rdy %b hold %b, required 0 1 1",
                 hdrs[h], bus.error, bus.in_ready, bus.pipe_hold);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s[$];
    bit saw_ready = 1'b0;
    s = '{8'h00, 8'h03};
    for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
    model(s);
    clear_mon();
    send(s, 1'b1);
    wait_done();
    // Trailing bytes after DONE must never be taken.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      if (bus.in_ready !== 1'b0) saw_ready = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    check_image("gaps");
    n_checks++;
    if (saw_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_trailing: got in_ready high after done, required low");
    end
  endtask

  task automatic test_restart_in_done();
    logic [7:0] s[$];
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.restart  = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done_ready: got in_ready %b, required 0", bus.in_ready);
    end
    cycle();
    bus.restart  = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.pipe_hold !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_done_next: got hold %b done %b rdy %b, required 1 0 1",
               bus.pipe_hold, bus.done, bus.in_ready);
    end
    s = '{8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    model(s);
    clear_mon();
    send(s, 1'b0);
    wait_done();
    check_image("reload");
  endtask

  task automatic test_rst_abort();
    logic [7:0] s[$];
    logic [7:0] p[$];
    do_restart();
    p = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    clear_mon();
    send(p, 1'b0);
    #2 rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if (wa.size() != 0) begin
      n_fail++;
      $display("FAIL abort_partial: got %0d writes, required 0", wa.size());
    end
    s = '{8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    model(s);
    clear_mon();
    send(s, 1'b0);
    wait_done();
    check_image("abort_reload");
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.restart  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_bad_header();
    test_gaps();
    test_restart_in_done();
    test_rst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
